// File: rtl/word_loader.sv
// Boot-time byte-stream loader: unpacks a length-prefixed, XOR-checked byte stream
// into 16-bit words with a one-cycle load strobe and a wrapping word address.
module word_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [15:0]       word_out,
    output logic              word_load,
    output logic [ADDR_W-1:0] word_addr,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LEN_HI  = 3'd1;
    localparam logic [2:0] LEN_LO  = 3'd2;
    localparam logic [2:0] DATA_HI = 3'd3;
    localparam logic [2:0] DATA_LO = 3'd4;
    localparam logic [2:0] CHECK   = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;
    localparam logic [2:0] ERR     = 3'd7;

    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        xor_q, xor_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       word_q, word_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        accept;
    logic [15:0] len_full;

    assign accept   = byte_valid && ready_q;
    assign len_full = {len_q[15:8], byte_in};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        xor_d   = xor_q;
        hi_d    = hi_q;
        word_d  = word_q;
        load_d  = 1'b0;
        addr_d  = addr_q;
        done_d  = done_q;
        err_d   = err_q;

        // Address advances the cycle after each strobe, so it equals the word index at the strobe.
        if (load_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    xor_d   = '0;
                    cnt_d   = '0;
                    addr_d  = '0;
                    len_d   = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d   = {byte_in, 8'h00};
                    xor_d   = xor_q ^ byte_in;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    xor_d = xor_q ^ byte_in;
                    if (32'(len_full) > MAX_LEN) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = byte_in;
                    xor_d   = xor_q ^ byte_in;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    word_d = {hi_q, byte_in};
                    load_d = 1'b1;
                    xor_d  = xor_q ^ byte_in;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (32'(cnt_q) + 32'd1 == 32'(len_q)) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (byte_in == xor_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
        busy_d  = ready_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            xor_q   <= '0;
            hi_q    <= '0;
            word_q  <= '0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
            hi_q    <= hi_d;
            word_q  <= word_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign byte_ready = ready_q;
    assign word_out   = word_q;
    assign word_load  = load_q;
    assign word_addr  = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_word_loader.sv
// Bench for word_loader (ADDR_W=4): fixed vectors, hand-written corner sequences and
// random streams checked against a stream-level reference model.
module tb_word_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [15:0]   word_out;
    logic          word_load;
    logic [AW-1:0] word_addr;
    logic          busy, done, error;

    word_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .word_out(word_out),
        .word_load(word_load), .word_addr(word_addr), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0]  stream_q [$];
    logic [31:0] got [$];
    logic [31:0] exp_q [$];
    logic        exp_done, exp_err;

    // Every strobe seen becomes one {addr, word} record.
    always @(negedge clk) begin
        if (word_load) got.push_back(32'({word_addr, word_out}));
    end

    typedef struct {
        logic [7:0]  b [8];
        int          n;
        int          stall;
        int          nld;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
        else passed++;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        chk("ready_before_start", 32'(byte_ready), 32'd0);
        got.delete();
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hEE;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("start_clears_flags", 32'({done, error}), 32'd0);
    endtask

    task automatic send_bytes(input int stall_pct);
        int idx = 0;
        int guard = 0;
        while (idx < stream_q.size() && guard < 5000) begin
            if (!busy) break;
            if ($urandom_range(0, 99) < stall_pct) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = stream_q[idx];
                if (byte_ready) idx++;
            end
            @(negedge clk);
            guard++;
        end
        byte_valid = 1'b0;
        if (guard >= 5000) begin
            total++;
            $display("FAIL send_timeout: got %0d bytes accepted, expected %0d", idx, stream_q.size());
        end
    endtask

    task automatic run_model();
        int len;
        logic [7:0] x;
        exp_q.delete();
        len = int'({stream_q[0], stream_q[1]});
        if (len > (1 << AW)) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        x = stream_q[0] ^ stream_q[1];
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(32'(((i % (1 << AW)) << 16) | int'({stream_q[2 + 2*i], stream_q[3 + 2*i]})));
            x = x ^ stream_q[2 + 2*i] ^ stream_q[3 + 2*i];
        end
        exp_done = (stream_q[2 + 2*len] == x);
        exp_err  = !exp_done;
    endtask

    task automatic check_model(input string name);
        chk({name, "_nloads"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({name, "_load"}, got[i], exp_q[i]);
        chk({name, "_done"}, 32'(done), 32'(exp_done));
        chk({name, "_error"}, 32'(error), 32'(exp_err));
        chk({name, "_idle"}, 32'({busy, byte_ready}), 32'd0);
    endtask

    task automatic run_vec(input int k);
        stream_q.delete();
        for (int i = 0; i < vecs[k].n; i++) stream_q.push_back(vecs[k].b[i]);
        start_pulse();
        send_bytes(vecs[k].stall);
        repeat (3) @(negedge clk);
        chk($sformatf("vec%0d_nloads", k), 32'(got.size()), 32'(vecs[k].nld));
        if (vecs[k].nld > 0) chk($sformatf("vec%0d_w0", k), (got.size() > 0) ? got[0] : 32'hDEAD_0000, vecs[k].e0);
        if (vecs[k].nld > 1) chk($sformatf("vec%0d_w1", k), (got.size() > 1) ? got[1] : 32'hDEAD_0000, vecs[k].e1);
        chk($sformatf("vec%0d_done", k), 32'(done), 32'(vecs[k].dn));
        chk($sformatf("vec%0d_error", k), 32'(error), 32'(vecs[k].er));
        chk($sformatf("vec%0d_idle", k), 32'({busy, byte_ready}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        int len;

        // check byte 0x42 = 00^02^12^34^AB^CD
        vecs[0] = '{'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h42,8'h00}, 7, 0,  2, 32'h0000_1234, 32'h0001_ABCD, 1'b1, 1'b0};
        vecs[1] = '{'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'hF1,8'h00}, 7, 0,  2, 32'h0000_1234, 32'h0001_ABCD, 1'b0, 1'b1};
        vecs[2] = '{'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0,  0, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{'{8'h00,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0,  0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{'{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h42,8'h00}, 7, 50, 2, 32'h0000_1234, 32'h0001_ABCD, 1'b1, 1'b0};
        vecs[5] = '{'{8'h00,8'h01,8'hFF,8'hFF,8'h01,8'h00,8'h00,8'h00}, 5, 0,  1, 32'h0000_FFFF, 32'h0, 1'b1, 1'b0};
        vecs[6] = '{'{8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0,  0, 32'h0, 32'h0, 1'b0, 1'b1};

        #3;
        chk("reset_outputs", 32'({byte_ready, word_out, word_load, word_addr, busy, done, error}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 7; k++) run_vec(k);

        // Reset right after the first word's strobe, then a clean reload.
        stream_q = '{8'h00, 8'h02, 8'h12, 8'h34};
        start_pulse();
        send_bytes(0);
        repeat (2) @(negedge clk);
        chk("reset_mid_one_load", 32'(got.size()), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("reset_mid_outputs", 32'({byte_ready, word_out, word_load, word_addr, busy, done, error}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_no_strobe", 32'(got.size()), 32'd1);
        run_vec(0);

        // start while busy must not restart the transfer.
        stream_q = '{8'h00, 8'h01};
        start_pulse();
        send_bytes(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored", 32'({busy, byte_ready}), 32'd3);
        stream_q = '{8'hAA, 8'h55, 8'hFE};
        send_bytes(0);
        repeat (3) @(negedge clk);
        chk("busy_start_nloads", 32'(got.size()), 32'd1);
        chk("busy_start_word", (got.size() > 0) ? got[0] : 32'hDEAD_0000, 32'h0000_AA55);
        chk("busy_start_done", 32'({done, error}), 32'd2);

        // Maximum legal length: 16 words fill every address, then the address wraps.
        stream_q = '{8'h00, 8'h10};
        for (int i = 0; i < 32; i++) stream_q.push_back(8'($urandom));
        x = '0;
        foreach (stream_q[i]) x ^= stream_q[i];
        stream_q.push_back(x);
        run_model();
        start_pulse();
        send_bytes(20);
        repeat (3) @(negedge clk);
        check_model("maxlen");
        chk("maxlen_addr_wrap", 32'(word_addr), 32'd0);

        // Random lengths (including illegal), data, stalls and check-byte corruption.
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(0, 18);
            stream_q = '{8'(len >> 8), 8'(len)};
            if (len <= (1 << AW)) begin
                for (int i = 0; i < 2*len; i++) stream_q.push_back(8'($urandom));
                x = '0;
                foreach (stream_q[i]) x ^= stream_q[i];
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                stream_q.push_back(x);
            end else begin
                stream_q.push_back(8'h5A);
                stream_q.push_back(8'hA5);
            end
            run_model();
            start_pulse();
            send_bytes($urandom_range(0, 60));
            repeat (3) @(negedge clk);
            check_model($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
